// File: rtl/accu_pkg.sv
// Shared definitions for the burst accumulator controller: FSM state encoding
// and default datapath widths.
package accu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } accu_state_t;

    localparam int ACCU_W     = 16;
    localparam int ACCU_CNT_W = 8;

endpackage

// File: rtl/accu_burst_ctrl_accumulator.sv
// Free-running accumulator: synchronous clear, adds d into acc whenever en is
// high, wrapping modulo 2^W.
module Accumulator #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] acc
);

    logic [W-1:0] acc_r;

    // Running sum register; clear wins over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= {W{1'b0}};
        end else if (en) begin
            acc_r <= acc_r + d;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/accu_burst_ctrl.sv
// Transaction wrapper around Accumulator: a command of N beats clears the sum,
// consumes N samples, then holds the result until the consumer takes it.
module accu_burst_ctrl
    import accu_pkg::*;
#(
    parameter int W     = ACCU_W,
    parameter int CNT_W = ACCU_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic             out_ovf,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    accu_state_t      state_r;
    accu_state_t      state_nx_s;
    logic [CNT_W-1:0] remaining_r;
    logic             flag_r;
    logic             cmd_ready_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;
    logic [W-1:0]     acc_s;
    logic [W:0]       sum_ext_s;
    logic             cmd_hs_s;
    logic             beat_s;
    logic             out_hs_s;
    logic             acc_clr_s;

    assign cmd_hs_s  = cmd_valid & cmd_ready_r;
    assign beat_s    = in_valid & in_ready_r;
    assign out_hs_s  = out_valid_r & out_ready;
    assign acc_clr_s = rst | cmd_hs_s;
    // Extra bit captures the carry out of the top sum bit for the overflow flag.
    assign sum_ext_s = {1'b0, acc_s} + {1'b0, in_data};

    Accumulator #(.W(W)) u_acc (
        .clk (clk),
        .rst (acc_clr_s),
        .en  (beat_s),
        .d   (in_data),
        .acc (acc_s)
    );

    // Next-state decode for the burst sequencer.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (cmd_hs_s) begin
                    if (cmd_len != CNT_ZERO) begin
                        state_nx_s = ACCUM;
                    end else begin
                        state_nx_s = DONE;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ACCUM: begin
                if (beat_s && (remaining_r == CNT_ONE)) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = ACCUM;
                end
            end
            DONE: begin
                if (out_hs_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State register with handshake flags registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cmd_ready_r <= 1'b1;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            cmd_ready_r <= (state_nx_s == IDLE);
            in_ready_r  <= (state_nx_s == ACCUM);
            out_valid_r <= (state_nx_s == DONE);
            busy_r      <= (state_nx_s != IDLE);
        end
    end

    // Beat counter and sticky carry flag for the current burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining_r <= CNT_ZERO;
            flag_r      <= 1'b0;
        end else if (cmd_hs_s) begin
            remaining_r <= cmd_len;
            flag_r      <= 1'b0;
        end else if (beat_s) begin
            remaining_r <= remaining_r - CNT_ONE;
            flag_r      <= flag_r | sum_ext_s[W];
        end else begin
            remaining_r <= remaining_r;
            flag_r      <= flag_r;
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_sum   = acc_s;
    assign out_ovf   = flag_r;
    assign busy      = busy_r;

endmodule

// File: doc/accu_burst_ctrl.md
# accu_burst_ctrl

Burst controller that sequences a shared `Accumulator` instance. A command of N beats clears the accumulator, streams exactly N input samples into it under valid/ready flow control, then presents the final sum on a result port until it is consumed. It sits between a sample producer and any consumer of block sums, and turns the free-running accumulator into a transaction-based datapath.

## Interface
Parameters:
- `W`, 16, sample and sum width; the sum wraps modulo 2^W.
- `CNT_W`, 8, burst-length width; the maximum burst is 2^CNT_W−1 beats.

Ports:
- `clk`  in  1  single clock, all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  burst command offered.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_len`  in  CNT_W  number of beats in the burst; 0 is legal.
- `in_valid`  in  1  sample offered.
- `in_ready`  out  1  controller accepts a sample this cycle.
- `in_data`  in  W  sample value.
- `out_valid`  out  1  result held on the output.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  W  accumulated sum, modulo 2^W.
- `out_ovf`  out  1  sticky flag: at least one addition in the burst carried out of bit W−1.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States:
  - **IDLE**: `cmd_ready=1`. On a command handshake:
    - the accumulator is cleared;
    - `remaining` is loaded with `cmd_len`;
    - the overflow flag is cleared;
    - next state is ACCUM if `cmd_len≠0`, otherwise DONE.
  - **ACCUM**: `in_ready=1`. Each `in_valid&&in_ready` beat asserts the accumulator enable with `d=in_data` and decrements `remaining`.
    - The overflow flag is set if bit W of `{1'b0,acc}+in_data` is 1.
    - A beat with `remaining==1` is the last one; next state is DONE.
    - Cycles with `in_valid=0` leave the accumulator and counter unchanged.
  - **DONE**: `out_valid=1`, `out_sum=acc`, `out_ovf=flag`. The accumulator enable is 0, so the outputs stay stable. On `out_ready`, next state is IDLE.
- The accumulator clear is the accumulator reset input, driven as `rst | (cmd_valid & cmd_ready)`.
- `in_ready` is 0 outside ACCUM, and `cmd_ready` is 0 outside IDLE. Extra samples and commands are back-pressured, never dropped.
- `cmd_len` is sampled only at the command handshake; later changes have no effect.
- Reset mid-burst: the next cycle is IDLE with the accumulator at 0, the flag at 0 and `remaining` at 0. Any partial burst is discarded without producing a result.
- Reset values: `cmd_ready=1`, `in_ready=0`, `out_valid=0`, `out_sum=0`, `out_ovf=0`, `busy=0`.

## Timing
- Command accepted at edge k → ACCUM, with `in_ready=1`, from cycle k+1. The accumulator reads 0 in cycle k+1.
- Throughput is one sample per cycle in ACCUM.
- Last beat accepted at edge m → `out_valid=1` in cycle m+1, with `out_sum` already including that beat.
- `cmd_len=0`: accepted at edge k → `out_valid=1`, `out_sum=0`, `out_ovf=0` in cycle k+1.
- A result handshake at edge r → `cmd_ready=1` in cycle r+1. There is no overlap between bursts: at least one IDLE cycle separates consecutive bursts.
- `out_valid`, `out_sum` and `out_ovf` do not change while `out_valid=1 && out_ready=0`.

## Structure
- Shared package `accu_pkg`:
  - state enum `accu_state_t` {IDLE, ACCUM, DONE};
  - default-width constants `ACCU_W=16` and `ACCU_CNT_W=8`.
- Sub-module: the existing `Accumulator #(W)`, ports (clk, rst, en, d, acc), instantiated once. Its `rst` is the clear term described under Operation.
- Overflow detection, the counter and the FSM live in `accu_burst_ctrl` itself.

## Test plan
- **Reset behaviour**: reset, then burst `cmd_len=4` with data 1,2,3,4 every cycle → `out_valid` 1 cycle after the 4th beat; `out_sum=10`, `out_ovf=0`.
- **Input stalls and output back-pressure**: `cmd_len=3`, samples 5,6,7 with `in_valid` gaps of 2 cycles, `out_ready` held low 5 cycles → `out_sum=18` stable throughout; `cmd_ready=0` until 1 cycle after `out_ready`.
- **Zero-length burst**: `cmd_len=0` → `out_valid` in the next cycle with `out_sum=0`, `out_ovf=0`; `in_ready` never asserts.
- **Wrap and overflow**: W=16, `cmd_len=2`, data 16'hFFFF, 16'h0003 → `out_sum=16'h0002`, `out_ovf=1`. The next burst `cmd_len=1`, data 7 → `out_sum=7`, `out_ovf=0`.
- **Reset mid-burst**: `cmd_len=5`, assert `rst` after 2 beats → IDLE next cycle, `out_valid` never rises. A following burst `cmd_len=1`, data 9 → `out_sum=9`.
- **Back-to-back bursts**: `cmd_valid` held high with lengths 2 then 2, data 1,1,2,2, `out_ready=1` → sums 2 then 4. No sample is counted twice or lost.
